// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_pkg                                                      |
// | Description : Shared datapath widths and ALU op encoding.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    localparam int C_XLEN       = 32;
    localparam int C_REG_ADDR_W = 5;
    localparam int C_CTRL_W     = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_stage_if                                           |
// | Description : Decode-side and ALU-side handshake bundle of the issue stage.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface alu_issue_stage_if
    import cpu_pkg::*;
#(
    parameter int XLEN       = C_XLEN,
    parameter int REG_ADDR_W = C_REG_ADDR_W,
    parameter int CTRL_W     = C_CTRL_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       in_pc;
    logic [REG_ADDR_W-1:0] in_rs1_addr;
    logic [REG_ADDR_W-1:0] in_rs2_addr;
    logic [XLEN-1:0]       in_rs1_data;
    logic [XLEN-1:0]       in_rs2_data;
    logic [XLEN-1:0]       in_imm;
    logic                  in_use_imm;
    logic                  in_use_pc;
    logic [CTRL_W-1:0]     in_alu_control;
    logic [REG_ADDR_W-1:0] in_rd_addr;
    logic                  in_rd_we;

    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       operand_a;
    logic [XLEN-1:0]       operand_b;
    logic [CTRL_W-1:0]     alu_control;
    logic [REG_ADDR_W-1:0] out_rd_addr;
    logic                  out_rd_we;
    logic [XLEN-1:0]       out_store_data;

    modport master (
        output in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_use_pc, in_alu_control, in_rd_addr, in_rd_we,
               out_ready,
        input  in_ready, out_valid, operand_a, operand_b, alu_control,
               out_rd_addr, out_rd_we, out_store_data
    );

    modport slave (
        input  in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_use_pc, in_alu_control, in_rd_addr, in_rd_we,
               out_ready,
        output in_ready, out_valid, operand_a, operand_b, alu_control,
               out_rd_addr, out_rd_we, out_store_data
    );
endinterface
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fwd_mux                                                      |
// | Description : Per-source operand bypass select and producer match flags.   |
// |               Bypass paths exist only when ALU_FWD_EN is defined.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int XLEN       = C_XLEN,
    parameter int REG_ADDR_W = C_REG_ADDR_W
) (
    input  wire logic [REG_ADDR_W-1:0] i_src_addr,
    input  wire logic [XLEN-1:0]       i_rf_data,
    input  wire logic                  i_ex_valid,
    input  wire logic [REG_ADDR_W-1:0] i_ex_rd,
    input  wire logic [XLEN-1:0]       i_ex_data,
    input  wire logic                  i_ex_is_load,
    input  wire logic                  i_wb_valid,
    input  wire logic [REG_ADDR_W-1:0] i_wb_rd,
    input  wire logic [XLEN-1:0]       i_wb_data,
    output logic      [XLEN-1:0]       o_data,
    output logic                       o_ex_match,
    output logic                       o_wb_match
);
    logic w_nonzero;

    // x0 never matches a producer, so it can neither bypass nor stall.
    assign w_nonzero  = |i_src_addr;
    assign o_ex_match = w_nonzero && i_ex_valid && (i_ex_rd == i_src_addr);
    assign o_wb_match = w_nonzero && i_wb_valid && (i_wb_rd == i_src_addr);

`ifdef ALU_FWD_EN
    always_comb begin
        o_data = i_rf_data;
        if (!w_nonzero) begin
            o_data = '0;
        end else if (o_ex_match && !i_ex_is_load) begin
            o_data = i_ex_data;
        end else if (o_wb_match) begin
            o_data = i_wb_data;
        end
    end
`else
    logic w_unused_fwd;

    assign o_data       = i_rf_data;
    assign w_unused_fwd = ^{i_ex_data, i_wb_data, i_ex_is_load};
`endif

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_stage                                              |
// | Description : ID/EX register feeding the ALU with operand bypass, hazard   |
// |               stalls and a saturating stall counter. Macro: ALU_FWD_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_issue_stage
    import cpu_pkg::*;
#(
    parameter int XLEN       = C_XLEN,
    parameter int REG_ADDR_W = C_REG_ADDR_W,
    parameter int CTRL_W     = C_CTRL_W
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  flush,
    input  wire logic                  fwd_ex_valid,
    input  wire logic [REG_ADDR_W-1:0] fwd_ex_rd,
    input  wire logic [XLEN-1:0]       fwd_ex_data,
    input  wire logic                  fwd_ex_is_load,
    input  wire logic                  fwd_wb_valid,
    input  wire logic [REG_ADDR_W-1:0] fwd_wb_rd,
    input  wire logic [XLEN-1:0]       fwd_wb_data,
    alu_issue_stage_if.slave           bus,
    output logic      [31:0]           stall_cnt
);
    localparam int C_NUM_SRC = 2;

    logic [REG_ADDR_W-1:0] w_src_addr [C_NUM_SRC];
    logic [XLEN-1:0]       w_src_rf   [C_NUM_SRC];
    logic [XLEN-1:0]       w_src_fwd  [C_NUM_SRC];
    logic                  w_ex_match [C_NUM_SRC];
    logic                  w_wb_match [C_NUM_SRC];

    logic                  w_hazard;
    logic                  w_in_ready;
    logic                  w_accept;
    logic [XLEN-1:0]       w_operand_a;
    logic [XLEN-1:0]       w_operand_b;

    logic                  r_out_valid;
    logic [XLEN-1:0]       r_operand_a;
    logic [XLEN-1:0]       r_operand_b;
    logic [CTRL_W-1:0]     r_alu_control;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic                  r_rd_we;
    logic [XLEN-1:0]       r_store_data;
    logic [31:0]           r_stall_cnt;

    assign w_src_addr[0] = bus.in_rs1_addr;
    assign w_src_addr[1] = bus.in_rs2_addr;
    assign w_src_rf[0]   = bus.in_rs1_data;
    assign w_src_rf[1]   = bus.in_rs2_data;

    for (genvar gi = 0; gi < C_NUM_SRC; gi++) begin : g_src
        fwd_mux #(
            .XLEN       (XLEN),
            .REG_ADDR_W (REG_ADDR_W)
        ) u_fwd_mux (
            .i_src_addr   (w_src_addr[gi]),
            .i_rf_data    (w_src_rf[gi]),
            .i_ex_valid   (fwd_ex_valid),
            .i_ex_rd      (fwd_ex_rd),
            .i_ex_data    (fwd_ex_data),
            .i_ex_is_load (fwd_ex_is_load),
            .i_wb_valid   (fwd_wb_valid),
            .i_wb_rd      (fwd_wb_rd),
            .i_wb_data    (fwd_wb_data),
            .o_data       (w_src_fwd[gi]),
            .o_ex_match   (w_ex_match[gi]),
            .o_wb_match   (w_wb_match[gi])
        );
    end

    // rs2 is compared even for immediate ops: stores still read it.
`ifdef ALU_FWD_EN
    logic w_unused_match;

    assign w_hazard       = fwd_ex_is_load &&
                            ((w_ex_match[0] && !bus.in_use_pc) || w_ex_match[1]);
    assign w_unused_match = w_wb_match[0] ^ w_wb_match[1];
`else
    assign w_hazard = ((w_ex_match[0] || w_wb_match[0]) && !bus.in_use_pc) ||
                      w_ex_match[1] || w_wb_match[1];
`endif

    assign w_in_ready  = (!r_out_valid || bus.out_ready) && !w_hazard && !flush;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_operand_a = bus.in_use_pc  ? bus.in_pc  : w_src_fwd[0];
    assign w_operand_b = bus.in_use_imm ? bus.in_imm : w_src_fwd[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_operand_a   <= '0;
            r_operand_b   <= '0;
            r_alu_control <= CTRL_W'(ALU_ADD);
            r_rd_addr     <= '0;
            r_rd_we       <= 1'b0;
            r_store_data  <= '0;
            r_stall_cnt   <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_operand_a   <= w_operand_a;
                r_operand_b   <= w_operand_b;
                r_alu_control <= bus.in_alu_control;
                r_rd_addr     <= bus.in_rd_addr;
                r_rd_we       <= bus.in_rd_we;
                r_store_data  <= w_src_fwd[1];
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (bus.in_valid && !w_in_ready && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = r_out_valid;
    assign bus.operand_a      = r_operand_a;
    assign bus.operand_b      = r_operand_b;
    assign bus.alu_control    = r_alu_control;
    assign bus.out_rd_addr    = r_rd_addr;
    assign bus.out_rd_we      = r_rd_we;
    assign bus.out_store_data = r_store_data;
    assign stall_cnt          = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_issue_stage                                           |
// | Description : Directed self-checking bench for alu_issue_stage; expected   |
// |               values follow ALU_FWD_EN when it is defined.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_issue_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        fwd_ex_valid = 1'b0;
    logic [4:0]  fwd_ex_rd = '0;
    logic [31:0] fwd_ex_data = '0;
    logic        fwd_ex_is_load = 1'b0;
    logic        fwd_wb_valid = 1'b0;
    logic [4:0]  fwd_wb_rd = '0;
    logic [31:0] fwd_wb_data = '0;
    logic [31:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;
    int exp_stall = 0;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .fwd_ex_valid   (fwd_ex_valid),
        .fwd_ex_rd      (fwd_ex_rd),
        .fwd_ex_data    (fwd_ex_data),
        .fwd_ex_is_load (fwd_ex_is_load),
        .fwd_wb_valid   (fwd_wb_valid),
        .fwd_wb_rd      (fwd_wb_rd),
        .fwd_wb_data    (fwd_wb_data),
        .bus            (bus),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] rs1a, input logic [31:0] rs1d,
                             input logic [4:0] rs2a, input logic [31:0] rs2d,
                             input logic [3:0] ctrl, input logic [4:0] rd);
        bus.in_valid       = 1'b1;
        bus.in_pc          = 32'h0000_1000;
        bus.in_rs1_addr    = rs1a;
        bus.in_rs1_data    = rs1d;
        bus.in_rs2_addr    = rs2a;
        bus.in_rs2_data    = rs2d;
        bus.in_imm         = 32'h0;
        bus.in_use_imm     = 1'b0;
        bus.in_use_pc      = 1'b0;
        bus.in_alu_control = ctrl;
        bus.in_rd_addr     = rd;
        bus.in_rd_we       = 1'b1;
    endtask

    task automatic clear_fwd();
        fwd_ex_valid = 1'b0; fwd_ex_rd = '0; fwd_ex_data = '0; fwd_ex_is_load = 1'b0;
        fwd_wb_valid = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
    endtask

    task automatic test_reset();
        set_instr(5'd1, 32'd9, 5'd2, 32'd8, ALU_OR, 5'd4);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        clear_fwd();
        rst_n = 1'b0;
        tick(); tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        vectors++; if (bus.operand_a !== 32'h0 || bus.operand_b !== 32'h0) begin miscompares++; $display("FAIL reset_operands got %h/%h exp 0/0", bus.operand_a, bus.operand_b); end
        vectors++; if (bus.alu_control !== 4'b0000) begin miscompares++; $display("FAIL reset_alu_control got %b exp 0000", bus.alu_control); end
        vectors++; if (bus.out_rd_we !== 1'b0 || bus.out_rd_addr !== 5'd0 || bus.out_store_data !== 32'h0) begin miscompares++; $display("FAIL reset_rd_store got we=%b rd=%0d sd=%h exp 0", bus.out_rd_we, bus.out_rd_addr, bus.out_store_data); end
        vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        set_instr(5'd1, 32'd15, 5'd2, 32'd10, ALU_SUB, 5'd3);
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_in_ready got %b exp 1", bus.in_ready); end
        tick();
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid got %b exp 1", bus.out_valid); end
        vectors++; if (bus.operand_a !== 32'd15 || bus.operand_b !== 32'd10) begin miscompares++; $display("FAIL basic_operands got %0d/%0d exp 15/10", bus.operand_a, bus.operand_b); end
        vectors++; if (bus.alu_control !== 4'b0001 || bus.out_rd_addr !== 5'd3 || bus.out_rd_we !== 1'b1) begin miscompares++; $display("FAIL basic_ctrl_rd got %b/%0d/%b exp 0001/3/1", bus.alu_control, bus.out_rd_addr, bus.out_rd_we); end
        vectors++; if (bus.out_store_data !== 32'd10) begin miscompares++; $display("FAIL basic_store_data got %0d exp 10", bus.out_store_data); end
        // pc and immediate operand selection; store data still carries rs2
        bus.in_use_pc = 1'b1; bus.in_pc = 32'h0000_0100;
        bus.in_use_imm = 1'b1; bus.in_imm = 32'hFFFF_FFFC;
        bus.in_alu_control = ALU_ADD;
        tick();
        vectors++; if (bus.operand_a !== 32'h0000_0100 || bus.operand_b !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL imm_pc_operands got %h/%h exp 00000100/fffffffc", bus.operand_a, bus.operand_b); end
        vectors++; if (bus.out_store_data !== 32'd10 || bus.alu_control !== 4'b0000) begin miscompares++; $display("FAIL imm_pc_store_ctrl got %h/%b exp 0000000a/0000", bus.out_store_data, bus.alu_control); end
        bus.in_valid = 1'b0;
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_out_valid got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_forward();
        set_instr(5'd5, 32'h55, 5'd6, 32'h66, ALU_ADD, 5'd8);
        fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd5; fwd_ex_data = 32'hAAAA_0000;
        fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd5; fwd_wb_data = 32'h1;
        #1;
`ifdef ALU_FWD_EN
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL fwd_in_ready got %b exp 1", bus.in_ready); end
        tick();
        vectors++; if (bus.operand_a !== 32'hAAAA_0000) begin miscompares++; $display("FAIL fwd_ex_priority got %h exp aaaa0000", bus.operand_a); end
        fwd_ex_valid = 1'b0;
        tick();
        vectors++; if (bus.operand_a !== 32'h1) begin miscompares++; $display("FAIL fwd_wb got %h exp 00000001", bus.operand_a); end
        bus.in_rs1_addr = 5'd0; bus.in_rs1_data = 32'h77;
        fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd0; fwd_wb_rd = 5'd0;
        tick();
        vectors++; if (bus.operand_a !== 32'h0) begin miscompares++; $display("FAIL fwd_x0 got %h exp 00000000", bus.operand_a); end
`else
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL nofwd_ex_stall got %b exp 0", bus.in_ready); end
        tick(); exp_stall++;
        fwd_ex_valid = 1'b0;
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL nofwd_wb_stall got %b exp 0", bus.in_ready); end
        tick(); exp_stall++;
        vectors++; if (stall_cnt !== 32'(exp_stall) || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL nofwd_stall_cnt got %0d/%b exp %0d/0", stall_cnt, bus.out_valid, exp_stall); end
        fwd_wb_valid = 1'b0;
        tick();
        vectors++; if (bus.operand_a !== 32'h55 || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL nofwd_rf_operand got %h/%b exp 00000055/1", bus.operand_a, bus.out_valid); end
        bus.in_rs1_addr = 5'd0; bus.in_rs1_data = 32'h77;
        fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd0; fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd0;
        tick();
        vectors++; if (bus.operand_a !== 32'h77) begin miscompares++; $display("FAIL nofwd_x0 got %h exp 00000077", bus.operand_a); end
        // rs1 unused when the PC is the A operand, so a matching producer must not stall
        bus.in_rs1_addr = 5'd5; bus.in_use_pc = 1'b1; bus.in_pc = 32'h200;
        fwd_ex_rd = 5'd5; fwd_wb_valid = 1'b0;
        tick();
        vectors++; if (bus.operand_a !== 32'h200) begin miscompares++; $display("FAIL nofwd_use_pc got %h exp 00000200", bus.operand_a); end
`endif
        clear_fwd();
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        set_instr(5'd1, 32'd3, 5'd7, 32'd50, ALU_ADD, 5'd9);
        fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd7; fwd_ex_is_load = 1'b1; fwd_ex_data = 32'hDEAD;
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL load_use_in_ready got %b exp 0", bus.in_ready); end
        tick(); tick(); tick(); exp_stall += 3;
        vectors++; if (stall_cnt !== 32'(exp_stall) || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL load_use_stall got %0d/%b exp %0d/0", stall_cnt, bus.out_valid, exp_stall); end
        fwd_ex_valid = 1'b0; fwd_ex_is_load = 1'b0;
        fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd7; fwd_wb_data = 32'd99;
`ifdef ALU_FWD_EN
        tick();
        vectors++; if (bus.operand_b !== 32'd99 || bus.out_store_data !== 32'd99) begin miscompares++; $display("FAIL load_use_wb_fwd got %0d/%0d exp 99/99", bus.operand_b, bus.out_store_data); end
`else
        tick(); exp_stall++;
        fwd_wb_valid = 1'b0;
        tick();
        vectors++; if (bus.operand_b !== 32'd50 || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL load_use_release got %0d/%b exp 50/1", bus.operand_b, bus.out_valid); end
`endif
        vectors++; if (stall_cnt !== 32'(exp_stall)) begin miscompares++; $display("FAIL load_use_stall_total got %0d exp %0d", stall_cnt, exp_stall); end
        clear_fwd();
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        set_instr(5'd1, 32'd100, 5'd2, 32'd200, ALU_XOR, 5'd10);
        tick();
        bus.out_ready = 1'b0;
        set_instr(5'd3, 32'd1, 5'd4, 32'd2, ALU_AND, 5'd11);
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %b exp 0", bus.in_ready); end
        tick(); tick(); tick(); exp_stall += 3;
        vectors++; if (bus.out_valid !== 1'b1 || bus.operand_a !== 32'd100 || bus.alu_control !== 4'b0101) begin miscompares++; $display("FAIL bp_hold got %b/%0d/%b exp 1/100/0101", bus.out_valid, bus.operand_a, bus.alu_control); end
        vectors++; if (stall_cnt !== 32'(exp_stall)) begin miscompares++; $display("FAIL bp_stall_cnt got %0d exp %0d", stall_cnt, exp_stall); end
        bus.out_ready = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %b exp 1", bus.in_ready); end
        tick();
        vectors++; if (bus.operand_a !== 32'd1 || bus.alu_control !== 4'b1001 || bus.out_rd_addr !== 5'd11) begin miscompares++; $display("FAIL bp_next_instr got %0d/%b/%0d exp 1/1001/11", bus.operand_a, bus.alu_control, bus.out_rd_addr); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        set_instr(5'd1, 32'd5, 5'd2, 32'd6, ALU_SLL, 5'd12);
        tick();
        bus.out_ready = 1'b0;
        set_instr(5'd3, 32'd7, 5'd4, 32'd8, ALU_OR, 5'd13);
        flush = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready got %b exp 0", bus.in_ready); end
        tick();
        vectors++; if (bus.out_valid !== 1'b0 || stall_cnt !== 32'(exp_stall)) begin miscompares++; $display("FAIL flush_kill got %b/%0d exp 0/%0d", bus.out_valid, stall_cnt, exp_stall); end
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_stall();
        set_instr(5'd1, 32'd21, 5'd2, 32'd22, ALU_SUB, 5'd14);
        tick();
        bus.out_ready = 1'b0;
        set_instr(5'd3, 32'd23, 5'd4, 32'd24, ALU_SRA, 5'd15);
        tick(); tick(); exp_stall += 2;
        vectors++; if (stall_cnt !== 32'(exp_stall)) begin miscompares++; $display("FAIL pre_reset_stall got %0d exp %0d", stall_cnt, exp_stall); end
        #2;
        rst_n = 1'b0;
        #1;
        exp_stall = 0;
        vectors++; if (bus.out_valid !== 1'b0 || bus.alu_control !== 4'b0000 || bus.operand_a !== 32'h0) begin miscompares++; $display("FAIL async_reset_regs got %b/%b/%h exp 0/0000/0", bus.out_valid, bus.alu_control, bus.operand_a); end
        vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL async_reset_stall got %0d exp 0", stall_cnt); end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
        vectors++; if (bus.out_valid !== 1'b0 || stall_cnt !== 32'd0) begin miscompares++; $display("FAIL no_replay got %b/%0d exp 0/0", bus.out_valid, stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_load_use();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX pipeline stage directly upstream of the ALU. Registers a decoded instruction and resolves operand forwarding and load-use hazards. Drives operand_a/operand_b/alu_control into the ALU through a valid/ready handshake. Also carries rd and store data downstream and counts stall cycles.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width
CTRL_W, 4, ALU control width (matches ALU op encoding)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill held/incoming instruction (branch/trap)
in_valid  in  1  decode has an instruction
in_ready  out  1  stage accepts this cycle
in_pc  in  XLEN  instruction PC
in_rs1_addr, in_rs2_addr  in  REG_ADDR_W  source indices
in_rs1_data, in_rs2_data  in  XLEN  register-file read data
in_imm  in  XLEN  sign-extended immediate
in_use_imm  in  1  operand_b = imm instead of rs2
in_use_pc  in  1  operand_a = pc instead of rs1
in_alu_control  in  CTRL_W  ALU op
in_rd_addr  in  REG_ADDR_W  destination
in_rd_we  in  1  destination write enable
fwd_ex_valid, fwd_ex_rd, fwd_ex_data, fwd_ex_is_load  in  1/REG_ADDR_W/XLEN/1  EX/MEM producer
fwd_wb_valid, fwd_wb_rd, fwd_wb_data  in  1/REG_ADDR_W/XLEN  MEM/WB producer
out_valid  out  1  registered instruction valid
out_ready  in  1  ALU/EX stage accepts
operand_a, operand_b  out  XLEN  to ALU
alu_control  out  CTRL_W  to ALU
out_rd_addr  out  REG_ADDR_W; out_rd_we  out  1
out_store_data  out  XLEN  forwarded rs2 value
stall_cnt  out  32  saturating stall counter

Behaviour:
- Reset (async, rst_n=0): out_valid=0, operands/store_data/rd=0, alu_control=4'b0000 (ADD), out_rd_we=0, stall_cnt=0.
- Transfer in on in_valid&&in_ready; outputs update the next edge (1-cycle latency). Out transfer on out_valid&&out_ready.
- in_ready = (!out_valid || out_ready) && !hazard && !flush. Output regs hold stable while out_valid&&!out_ready.
- Forwarding per source (rs1/rs2): if addr==0 -> 0. Else if fwd_ex_valid&&fwd_ex_rd==addr&&!fwd_ex_is_load -> fwd_ex_data. Else if fwd_wb_valid&&fwd_wb_rd==addr -> fwd_wb_data. Else RF data. EX has priority over WB.
- operand_a = in_use_pc ? in_pc : fwd_rs1. operand_b = in_use_imm ? in_imm : fwd_rs2. out_store_data = fwd_rs2 always.
- hazard (load-use): fwd_ex_valid && fwd_ex_is_load && fwd_ex_rd!=0 && ((fwd_ex_rd==rs1 && !in_use_pc) || fwd_ex_rd==rs2). This is a conservative rs2 compare.
- flush: next edge out_valid=0 and no capture. Flush beats capture and beats a held instruction. Other output regs may hold.
- stall_cnt increments when in_valid&&!in_ready&&!flush; saturates at 32'hFFFF_FFFF, no wrap.
- Reset mid-stall: all state clears immediately; no instruction is replayed.

Optional Feature:
ALU_FWD_EN defined: forwarding as above.
Undefined: no bypass, operands come from RF data only. hazard also asserts on any valid fwd_ex or fwd_wb rd!=0 matching a used source (load or not), and the stage stalls until clear. stall_cnt counts these stalls.

Decomposition:
- Shared package cpu_pkg: XLEN, REG_ADDR_W, ALU op constants ALU_ADD=0000, ALU_SUB=0001, ALU_SLL=0010, ALU_SLT=0011, ALU_SLTU=0100, ALU_XOR=0101, ALU_SRL=0110, ALU_SRA=0111, ALU_OR=1000, ALU_AND=1001.
- Sub-module fwd_mux (combinational source select + match flags), instantiated twice (rs1, rs2).

Test Plan:
- Basic: rs1_data=15, rs2_data=10, ctrl=0001, out_ready=1 -> next cycle out_valid=1, operand_a=15, operand_b=10, alu_control=0001.
- Forward priority: rs1_addr=5, fwd_ex(rd5,data 32'hAAAA_0000), fwd_wb(rd5,data 32'h1) -> operand_a=32'hAAAA_0000; with ex invalid -> 32'h1; rs1_addr=0 with both matching -> 0.
- Load-use: fwd_ex_is_load=1, fwd_ex_rd=rs2=7, in_valid=1 -> in_ready=0, stall_cnt +1 per cycle; load cleared with wb rd7=99 -> accepted, operand_b=99.
- Backpressure: out_ready=0 for 3 cycles with a new in_valid -> in_ready=0, outputs unchanged, stall_cnt=3; out_ready=1 -> next instruction loads.
- Flush: flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0, incoming instruction dropped.
- Reset mid-stall: rst_n=0 while stalled -> out_valid=0, alu_control=0000, stall_cnt=0 immediately (asynchronous).
